// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the core pipeline and a
// single-ported word memory. One access in flight at a time; sub-word
// stores are replicated across lanes, sub-word loads are extracted and
// sign/zero-extended on return.
//
// state | meaning
// IDLE  | waiting for a core request; decode and alignment check
// BUSY  | memory request outstanding, fields held constant until ready
// DONE  | load data presented, pipeline released for one cycle
module lsu_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    state_t      state_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] rd_q;

    logic        req_bad;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] rd_ext;

    // Request decode: illegal sizes, stores of unsigned widths and misalignment all reject.
    always_comb begin
        req_bad = 1'b0;
        be_next = 4'b0000;
        wd_next = core_wd_i;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                req_bad = core_we_i && (core_size_i == LDST_BU);
                be_next = 4'b0001 << core_addr_i[1:0];
                wd_next = {4{core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                req_bad = core_addr_i[0] || (core_we_i && (core_size_i == LDST_HU));
                be_next = 4'b0011 << core_addr_i[1:0];
                wd_next = {2{core_wd_i[15:0]}};
            end
            LDST_W: begin
                req_bad = (core_addr_i[1:0] != 2'b00);
                be_next = 4'b1111;
                wd_next = core_wd_i;
            end
            default: req_bad = 1'b1;
        endcase
    end

    // Load extraction from the returned word using the latched size and offset.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = mem_rd_i[8*off_q +: 8];
        half_sel = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            LDST_B:  rd_ext = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rd_ext = {24'h0, byte_sel};
            LDST_H:  rd_ext = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rd_ext = {16'h0, half_sel};
            default: rd_ext = mem_rd_i;
        endcase
    end

    // Sequencer: latch the access in IDLE, hold it through BUSY, release in DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_req_i && !req_bad) begin
                        size_q  <= core_size_i;
                        off_q   <= core_addr_i[1:0];
                        we_q    <= core_we_i;
                        be_q    <= be_next;
                        addr_q  <= {core_addr_i[31:2], 2'b00};
                        wd_q    <= wd_next;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        if (!we_q) begin
                            rd_q <= rd_ext;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Core-facing handshake: stall goes high the same cycle a legal request is seen.
    always_comb begin
        core_stall_o    = (state_q == BUSY) ||
                          ((state_q == IDLE) && core_req_i && !req_bad);
        core_misalign_o = (state_q == IDLE) && core_req_i && req_bad;
    end

    assign mem_req_o  = (state_q == BUSY);
    assign mem_we_o   = we_q;
    assign mem_be_o   = be_q;
    assign mem_addr_o = addr_q;
    assign mem_wd_o   = wd_q;
    assign core_rd_o  = rd_q;

endmodule
